// File: rtl/apb_regfile_pkg.sv
// Shared types, constants and helpers for the APB register-file completer.
package apb_regfile_pkg;

  // Completer transfer state: waiting for a setup phase, or inside the access phase.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // Registers are 32-bit words, so the two low address bits select a byte.
  localparam int unsigned ADDR_LSB = 2;
  localparam int unsigned STRB_W   = 4;

  // True when paddr falls inside [base, base + 4*num). The arithmetic is done
  // in 64 bits so the upper bound cannot wrap for bases near the top of the map.
  function automatic logic addr_in_range(input logic [63:0] paddr,
                                         input logic [63:0] base,
                                         input int unsigned num);
    return (paddr >= base) && (paddr < (base + (64'(num) << ADDR_LSB)));
  endfunction

endpackage

// File: rtl/apb_regfile_decode.sv
// Combinational address decode of the captured transfer address: validity,
// register index and whether the addressed register is read-only.
module apb_regfile_decode
  import apb_regfile_pkg::*;
#(
  parameter int unsigned         ADDR_W    = 32,
  parameter int unsigned         NUM_REGS  = 8,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = 32'hA000,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
  parameter int unsigned         IDX_W     = 3
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              valid,
  output logic [IDX_W-1:0]  idx,
  output logic              ro_hit
);

  // Range plus word alignment gives validity; the index is the word offset from the base.
  always_comb begin
    valid  = addr_in_range(64'(addr), 64'(BASE_ADDR), NUM_REGS) &&
             (addr[ADDR_LSB-1:0] == '0);
    idx    = IDX_W'((addr - BASE_ADDR) >> ADDR_LSB);
    ro_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (valid && (idx == IDX_W'(i)) && RO_MASK[i]) begin
        ro_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB4 completer fronting a bank of 32-bit registers with wait states,
// byte strobes, read-only slots backed by hw_status, and error responses.
//
// Handshake: a transfer starts with a setup cycle (psel & !penable) in IDLE;
// the completer then holds pready low for WAIT_STATES cycles of the access
// phase and raises it for the completing cycle. The transfer completes on the
// clock edge where psel & penable & pready are all high; prdata/pslverr are
// meaningful only while pready is high. Dropping psel before that edge aborts
// the transfer with no side effects.
module apb_regfile_slave
  import apb_regfile_pkg::*;
#(
  parameter int unsigned         DATA_W      = 32,
  parameter int unsigned         ADDR_W      = 32,
  parameter int unsigned         NUM_REGS    = 8,
  parameter logic [ADDR_W-1:0]   BASE_ADDR   = 32'hA000,
  parameter int unsigned         WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
  input  logic                       pclk,
  input  logic                       preset,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic [DATA_W-1:0]          pwdata,
  input  logic [STRB_W-1:0]          pstrb,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pready,
  output logic                       pslverr,
  input  logic [NUM_REGS*DATA_W-1:0] hw_status,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        reg_wr,
  output apb_state_e                 dbg_state
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CNT_W = 4;

  if (DATA_W != 32) begin : g_bad_data_w
    $error("apb_regfile_slave: DATA_W must be 32");
  end
  if ((NUM_REGS < 1) || (NUM_REGS > 256)) begin : g_bad_num_regs
    $error("apb_regfile_slave: NUM_REGS must be 1..256");
  end
  if (WAIT_STATES > 15) begin : g_bad_wait
    $error("apb_regfile_slave: WAIT_STATES must be 0..15");
  end
  if (BASE_ADDR[ADDR_LSB-1:0] != '0) begin : g_bad_base
    $error("apb_regfile_slave: BASE_ADDR must be 4-aligned");
  end

  apb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               write_q, write_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]  strb_q, strb_d;
  logic               pready_q, pready_d;
  logic [DATA_W-1:0]  prdata_q, prdata_d;
  logic               pslverr_q, pslverr_d;
  logic [NUM_REGS-1:0] reg_wr_q, reg_wr_d;
  logic [DATA_W-1:0]  regs_q [NUM_REGS];
  logic [DATA_W-1:0]  regs_d [NUM_REGS];
  logic               commit;
  logic [DATA_W-1:0]  rd_val;
  logic               dec_valid;
  logic [IDX_W-1:0]   dec_idx;
  logic               dec_ro;

  // Capture address/control/data during the setup cycle; hold them through access.
  always_comb begin
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    if ((state_q == IDLE) && psel && !penable) begin
      addr_d  = paddr;
      write_d = pwrite;
      wdata_d = pwdata;
      strb_d  = pstrb;
    end
  end

  // The decode looks at the value being captured so a zero-wait response can
  // be loaded on the same edge that captures the setup phase.
  apb_regfile_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .BASE_ADDR(BASE_ADDR),
    .RO_MASK  (RO_MASK),
    .IDX_W    (IDX_W)
  ) u_decode (
    .addr  (addr_d),
    .valid (dec_valid),
    .idx   (dec_idx),
    .ro_hit(dec_ro)
  );

  // Next-state logic: setup entry, wait-state countdown, completion and abort.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // psel & penable without a preceding setup is ignored.
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (penable && pready_q) begin
          state_d = IDLE;
          commit  = write_q && dec_valid && !dec_ro;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte-strobed register update and write pulse on the completing edge.
  always_comb begin
    regs_d   = regs_q;
    reg_wr_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit && (dec_idx == IDX_W'(i))) begin
        reg_wr_d[i] = 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          if (strb_q[b]) begin
            regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
          end
        end
      end
      if (RO_MASK[i]) begin
        regs_d[i] = '0;
      end
    end
  end

  // Response: pready is a decode of the next state; data/error load as it rises.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (dec_idx == IDX_W'(i)) begin
        rd_val = RO_MASK[i] ? hw_status[i*DATA_W +: DATA_W] : regs_q[i];
      end
    end
    pready_d  = (state_d == ACCESS) && (cnt_d == '0);
    prdata_d  = '0;
    pslverr_d = 1'b0;
    if (pready_d && pready_q) begin
      prdata_d  = prdata_q;
      pslverr_d = pslverr_q;
    end else if (pready_d) begin
      pslverr_d = !dec_valid || (write_d && dec_ro);
      prdata_d  = (dec_valid && !write_d) ? rd_val : '0;
    end
  end

  // State, capture, response and register-bank flops with synchronous reset.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      reg_wr_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RO_MASK[i] ? '0 : RESET_VAL;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      reg_wr_q  <= reg_wr_d;
      regs_q    <= regs_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign reg_wr    = reg_wr_q;
  assign dbg_state = state_q;

endmodule

// File: doc/apb_regfile_slave.md
# apb_regfile_slave

Parametrised APB4 completer: a bank of `NUM_REGS` 32-bit registers at `BASE_ADDR`, with configurable wait states, byte strobes, per-register read-only masking and error response. It sits behind the APB master as the generalised successor of the single-register slave. Hardware-side outputs expose register contents and write pulses to downstream logic.

## Interface
- `DATA_W`, 32: data width; only 32 supported, checked at elaboration.
- `ADDR_W`, 32: `paddr` width.
- `NUM_REGS`, 8: register count, 1..256.
- `BASE_ADDR`, 32'hA000: byte address of register 0; must be 4-aligned.
- `WAIT_STATES`, 0: extra access cycles before `pready`, 0..15.
- `RO_MASK`, '0: bit i=1 makes register i read-only; it then reads `hw_status[i]`.
- `RESET_VAL`, '0: reset value applied to every RW register.

Ports:
- `pclk` in 1: clock.
- `preset` in 1: reset, synchronous active-high.
- `psel`, `penable`, `pwrite` in 1: APB control.
- `paddr` in `ADDR_W`: byte address.
- `pwdata` in 32: write data.
- `pstrb` in 4: byte write strobes.
- `prdata` out 32: read data.
- `pready` out 1: transfer complete.
- `pslverr` out 1: error response.
- `hw_status` in `NUM_REGS*32`: values for RO registers.
- `reg_q` out `NUM_REGS*32`: current RW register contents; RO slots read 0.
- `reg_wr` out `NUM_REGS`: one-cycle pulse per committed write.

## Operation
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS on `psel & !penable` (setup phase). The down-counter is loaded with `WAIT_STATES`.
  - In ACCESS the counter decrements each cycle while nonzero.
  - `pready` = ACCESS & counter==0; it is a registered state decode.
  - ACCESS -> IDLE at the edge where `psel & penable & pready`.
  - ACCESS -> IDLE if `psel` drops before completion (abort). An abort performs no write and no pulse.
  - `psel & penable` seen in IDLE is a protocol violation: ignored, stays IDLE, `pready` stays 0.
- Decode: the transfer is valid iff all of the following hold:
  - `paddr >= BASE_ADDR`;
  - `paddr < BASE_ADDR + 4*NUM_REGS`;
  - `paddr[1:0] == 0`.
  - Index = `(paddr - BASE_ADDR) >> 2`.
- Error: `pslverr=1` for any invalid address, or for a write to an RO register. There is no state change and `prdata=0`.
- Write commit at the completing edge: for each byte b with `pstrb[b]=1`, `reg[idx][8b+7:8b] <= pwdata[8b+7:8b]`. `reg_wr[idx]` pulses the following cycle, including when `pstrb=0`.
- Read: `prdata` returns `reg[idx]` for RW, `hw_status[idx]` for RO. `pstrb` is ignored on reads.
- Addresses and data are captured in the setup cycle. `paddr`/`pwrite`/`pwdata` must stay stable through access; the block uses the registered copy.

## Timing
- Reset (synchronous, priority over everything):
  - RW registers = `RESET_VAL`; state IDLE; counter 0.
  - `pready`=0, `pslverr`=0, `prdata`=0, `reg_wr`=0.
  - Reset mid-transfer abandons it with no write.
- Latency:
  - Setup at cycle N gives `pready=1` in cycle N+1+`WAIT_STATES`.
  - Zero-wait transfer = 2 cycles.
- `prdata` and `pslverr` are registered, loaded on the edge that makes `pready` 1. They are valid only while `pready=1` and are 0 in all other cycles.
- Back-to-back: a new setup may occur in the cycle after completion. The previous write is visible to that read.
- `hw_status` is sampled on the edge that loads `prdata`.
- `reg_q` updates on the commit edge. `reg_wr` is high exactly one cycle after the commit edge.

## Structure
- Package `apb_regfile_pkg`:
  - state enum `apb_state_e` {IDLE, ACCESS};
  - localparams `ADDR_LSB=2`, `STRB_W=4`;
  - function `addr_in_range(paddr, base, num)`.
- Sub-module `apb_regfile_decode`: combinational valid/index/RO-hit decode from the captured address. The top holds the FSM, counter and register array.

## Test plan
- Reset, then read `0xA000`..`0xA01C` -> `pready` after 2 cycles, `prdata=0`, `pslverr=0`.
- Write `0xDEADBEEF` to `0xA004` with `pstrb=4'b0101`, starting from 0 -> read returns `0x00AD00EF`; `reg_wr[1]` pulses once.
- `WAIT_STATES=3`: write then read `0xA008` -> `pready` in the 5th cycle after setup; data correct.
- Access `0xA020` (out of range) and `0xA002` (misaligned) -> `pslverr=1`, `prdata=0`, no register changes.
- `RO_MASK=8'h80`, `hw_status[7]=0x12345678`: write `0xA01C` -> `pslverr=1`; read `0xA01C` -> `0x12345678`.
- `preset` asserted mid-wait of a write to `0xA000` -> no `reg_wr` pulse; register reads `RESET_VAL`; FSM IDLE.
